// File: rtl/logic_pkg.sv
// Shared opcode definitions for the bitwise word logic datapath.
package logic_pkg;

  localparam int unsigned OpWidth = 3;

  typedef enum logic [OpWidth-1:0] {
    OpNotA  = 3'd0,
    OpAnd   = 3'd1,
    OpOr    = 3'd2,
    OpXor   = 3'd3,
    OpNand  = 3'd4,
    OpNor   = 3'd5,
    OpXnor  = 3'd6,
    OpPassA = 3'd7
  } op_e;

endpackage

// File: rtl/word_logic_unit_if.sv
// Operation request / result handshake bundle for word_logic_unit.
interface word_logic_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  import logic_pkg::*;

  localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic                in_ready;
  op_e                 op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic [CntWidth-1:0] count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, count
  );

endinterface

// File: rtl/word_logic_core.sv
// Purely combinational bitwise operator; every result bit depends only on the same bit of a/b.
module word_logic_core
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    unique case (op)
      OpNotA:  y = ~a;
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpNand:  y = ~(a & b);
      OpNor:   y = ~(a | b);
      OpXnor:  y = ~(a ^ b);
      OpPassA: y = a;
    endcase
  end

endmodule

// File: rtl/word_logic_unit.sv
// Bitwise logic unit: results are computed on accept and queued in a small FIFO
// that drains in accept order.
module word_logic_unit
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  word_logic_unit_if.slave bus
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                in_ready_q;
  logic                accept, pop;
  logic [WIDTH-1:0]    y;

  word_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op(bus.op),
    .a (bus.a),
    .b (bus.b),
    .y (y)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = (count_q != '0) & bus.out_ready;

  // Pointers wrap for free since DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (accept) wptr_d = wptr_q + 1'b1;
    if (pop)    rptr_d = rptr_q + 1'b1;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // in_ready is registered from next-state count so it stays low through reset
  // and never combinationally depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != CntFull);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= y;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.result    = mem_q[rptr_q];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_word_logic_unit.sv
// Directed bench for word_logic_unit at 8x2 and 32x4 configurations.
module tb_word_logic_unit;
  import logic_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  word_logic_unit_if #(.WIDTH(8),  .DEPTH(2)) bus8 ();
  word_logic_unit_if #(.WIDTH(32), .DEPTH(4)) bus32 ();

  word_logic_unit #(.WIDTH(8), .DEPTH(2)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  word_logic_unit #(.WIDTH(32), .DEPTH(4)) u_dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_op(op_e o, logic [7:0] x, logic [7:0] z);
    case (o)
      OpNotA:  return ~x;
      OpAnd:   return x & z;
      OpOr:    return x | z;
      OpXor:   return x ^ z;
      OpNand:  return ~(x & z);
      OpNor:   return ~(x | z);
      OpXnor:  return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    n_checks++; if (bus8.count !== 2'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", bus8.count); end
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus8.out_valid); end
    n_checks++; if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bus8.in_ready); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_early: got %b expected 0", bus8.in_ready); end
    step();
    n_checks++; if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b expected 1", bus8.in_ready); end
    n_checks++; if (bus8.count !== 2'd0) begin n_fail++; $display("FAIL rel_count: got %0d expected 0", bus8.count); end
  endtask

  task automatic test_not();
    bus8.in_valid  = 1'b1;
    bus8.op        = OpNotA;
    bus8.a         = 8'h5A;
    bus8.b         = 8'h00;
    bus8.out_ready = 1'b1;
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL not_pre_valid: got %b expected 0", bus8.out_valid); end
    step();
    bus8.in_valid = 1'b0;
    n_checks++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL not_valid: got %b expected 1", bus8.out_valid); end
    n_checks++; if (bus8.result !== 8'hA5) begin n_fail++; $display("FAIL not_result: got %h expected a5", bus8.result); end
    step();
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL not_drained: got %b expected 0", bus8.out_valid); end
  endtask

  task automatic test_full();
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.op = OpAnd; bus8.a = 8'hF0; bus8.b = 8'h3C;
    step();
    bus8.op = OpOr;  bus8.a = 8'hF0; bus8.b = 8'h0F;
    step();
    bus8.op = OpXor; bus8.a = 8'hFF; bus8.b = 8'h0F;
    n_checks++; if (bus8.count !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d expected 2", bus8.count); end
    n_checks++; if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", bus8.in_ready); end
    n_checks++; if (bus8.result !== 8'h30) begin n_fail++; $display("FAIL full_head: got %h expected 30", bus8.result); end
    step();
    n_checks++; if (bus8.count !== 2'd2) begin n_fail++; $display("FAIL full_hold_count: got %0d expected 2", bus8.count); end
    n_checks++; if (bus8.result !== 8'h30) begin n_fail++; $display("FAIL full_hold_head: got %h expected 30", bus8.result); end
    bus8.out_ready = 1'b1;
    step();
    n_checks++; if (bus8.count !== 2'd1) begin n_fail++; $display("FAIL drain1_count: got %0d expected 1", bus8.count); end
    n_checks++; if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL drain1_in_ready: got %b expected 1", bus8.in_ready); end
    n_checks++; if (bus8.result !== 8'hFF) begin n_fail++; $display("FAIL drain1_result: got %h expected ff", bus8.result); end
    step();
    bus8.in_valid = 1'b0;
    n_checks++; if (bus8.count !== 2'd1) begin n_fail++; $display("FAIL xor_count: got %0d expected 1", bus8.count); end
    n_checks++; if (bus8.result !== 8'hF0) begin n_fail++; $display("FAIL xor_result: got %h expected f0", bus8.result); end
    step();
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", bus8.out_valid); end
  endtask

  task automatic test_full_pop();
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.op = OpPassA; bus8.a = 8'h11; bus8.b = 8'hEE;
    step();
    bus8.a = 8'h22;
    step();
    bus8.a = 8'h33;
    bus8.out_ready = 1'b1;
    n_checks++; if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_in_ready_full: got %b expected 0", bus8.in_ready); end
    step();
    bus8.in_valid = 1'b0;
    n_checks++; if (bus8.count !== 2'd1) begin n_fail++; $display("FAIL fp_count: got %0d expected 1", bus8.count); end
    n_checks++; if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL fp_in_ready: got %b expected 1", bus8.in_ready); end
    n_checks++; if (bus8.result !== 8'h22) begin n_fail++; $display("FAIL fp_result: got %h expected 22", bus8.result); end
    step();
    n_checks++; if (bus8.count !== 2'd0) begin n_fail++; $display("FAIL fp_empty: got %0d expected 0", bus8.count); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < 20 || exp_q.size() != 0) && cyc < 300) begin
      bus8.out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        bus8.in_valid = 1'b1;
        bus8.op = op_e'(3'(sent % 8));
        bus8.a  = 8'(sent * 29 + 3);
        bus8.b  = 8'(sent * 71 + 5);
      end else begin
        bus8.in_valid = 1'b0;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got %h expected no result", bus8.result);
        end else begin
          if (bus8.result !== exp_q[0]) begin
            n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", got, bus8.result, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(ref_op(bus8.op, bus8.a, bus8.b));
        sent++;
      end
      step();
      cyc++;
      n_checks++;
      if (bus8.count !== exp_q.size()) begin
        n_fail++; $display("FAIL stream_count: got %0d expected %0d", bus8.count, exp_q.size());
      end
    end
    bus8.in_valid = 1'b0;
    n_checks++; if (cyc >= 300) begin n_fail++; $display("FAIL stream_timeout: got %0d cycles expected < 300", cyc); end
    n_checks++; if (got != 20) begin n_fail++; $display("FAIL stream_total: got %0d expected 20", got); end
  endtask

  task automatic test_reset_mid();
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.op = OpOr; bus8.a = 8'h81; bus8.b = 8'h18;
    step();
    bus8.a = 8'h42;
    step();
    bus8.in_valid = 1'b0;
    n_checks++; if (bus8.count !== 2'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", bus8.count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", bus8.out_valid); end
    n_checks++; if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 0", bus8.in_ready); end
    #1;
    rst_n = 1'b1;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost[%0d]: got %b expected 0", i, bus8.out_valid); end
    end
    n_checks++; if (bus8.count !== 2'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", bus8.count); end
    n_checks++; if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", bus8.in_ready); end
  endtask

  task automatic test_wide();
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    bus32.op = OpNand; bus32.a = 32'hFFFF0000; bus32.b = 32'hFF00FF00;
    step();
    n_checks++; if (bus32.result !== 32'h00FFFFFF) begin n_fail++; $display("FAIL wide_nand: got %h expected 00ffffff", bus32.result); end
    bus32.op = OpNor; bus32.a = 32'h0; bus32.b = 32'h0;
    step();
    n_checks++; if (bus32.result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wide_nor: got %h expected ffffffff", bus32.result); end
    bus32.op = OpXnor; bus32.a = 32'h1234ABCD; bus32.b = 32'h1234ABCD;
    step();
    bus32.in_valid = 1'b0;
    n_checks++; if (bus32.result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wide_xnor: got %h expected ffffffff", bus32.result); end
    n_checks++; if (bus32.count !== 3'd1) begin n_fail++; $display("FAIL wide_count: got %0d expected 1", bus32.count); end
    step();
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL wide_empty: got %b expected 0", bus32.out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus8.in_valid  = 1'b0; bus8.op  = OpNotA; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b0;
    bus32.in_valid = 1'b0; bus32.op = OpNotA; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b0;
    test_reset();
    test_not();
    test_full();
    test_full_pop();
    test_stream();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_logic_unit.md
WORD_LOGIC_UNIT -- requirements
Module: word_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the result buffer depth in entries; legal values are 2..16, powers of two only.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, with ports clk and rst_n.
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port in_valid  input  1  an operation is offered this cycle.
REQ-007 Port in_ready  output  1  the block accepts the offered operation this cycle.
REQ-008 Port op  input  3  opcode: 0 NOT_A, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS_A.
REQ-009 Port a  input  WIDTH  first operand.
REQ-010 Port b  input  WIDTH  second operand; ignored for NOT_A and PASS_A.
REQ-011 Port out_valid  output  1  a result is presented.
REQ-012 Port out_ready  input  1  the consumer takes the presented result this cycle.
REQ-013 Port result  output  WIDTH  the result at the head of the buffer.
REQ-014 Port count  output  $clog2(DEPTH)+1  number of buffered results.

Function
REQ-015 An accept SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 The block SHALL compute each result bitwise per op, with every bit independent and no carries.
REQ-017 The block SHALL register the result into the FIFO on the accepting edge, giving out_valid 1 cycle after the accept when the buffer was empty (latency 1).
REQ-018 in_ready SHALL equal (count != DEPTH) and SHALL be a function of state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0), and result SHALL be driven from the head entry.
REQ-020 The block SHALL deliver results in accept order, with no loss or duplication.
REQ-021 When an accept and a pop occur together, count SHALL be unchanged, and both the write and read pointers SHALL advance.
REQ-022 When full, in_valid SHALL be ignored and no state SHALL change except by a pop; a pop while full SHALL raise in_ready in the next cycle.
REQ-023 When empty, out_ready SHALL be ignored, and count SHALL never underflow.
REQ-024 The write and read pointers SHALL wrap modulo DEPTH.
REQ-025 Once out_valid is 1, result SHALL hold stable until popped, regardless of the inputs.
REQ-026 An op code outside the defined set cannot occur because op is 3 bits and fully decoded.

Reset
REQ-027 While rst_n is 0, the block SHALL force count=0, out_valid=0, in_ready=0, and the pointers to 0, asynchronously.
REQ-028 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Buffer data SHALL NOT be reset, and result SHALL be don't-care while out_valid is 0.
REQ-030 A reset asserted mid-operation SHALL discard all buffered results, and the block SHALL produce no output for operations accepted before reset.

Structure
REQ-031 The opcode enumeration and its 3-bit width SHALL live in the shared package logic_pkg.
REQ-032 The combinational bitwise datapath SHALL be the sub-module word_logic_core (parameter WIDTH; ports op, a, b, y), instantiated once.
REQ-033 FIFO storage, pointers and count SHALL reside in word_logic_unit.

Verification
REQ-034 WIDTH=8: reset, then accept op=NOT_A with a=0x5A and out_ready=1 -> result=0xA5 with out_valid high exactly 1 cycle after the accept.
REQ-035 WIDTH=8, DEPTH=2: hold out_ready=0 and issue AND(0xF0,0x3C), OR(0xF0,0x0F), then XOR -> count=2, in_ready=0, and the XOR is not accepted; release out_ready -> 0x30 then 0xFF, after which XOR(0xFF,0x0F)=0xF0 is accepted.
REQ-036 WIDTH=8: full buffer with in_valid=1 and out_ready=1 in the same cycle -> one pop and no accept, count goes from 2 to 1, and in_ready=1 next cycle.
REQ-037 WIDTH=8: a continuous stream of 20 ops with random out_ready -> outputs match a reference model in order, and the pointers wrap without error.
REQ-038 WIDTH=8: assert rst_n=0 with 2 results buffered -> out_valid=0 immediately, and after release count=0 with the old results never appearing.
REQ-039 WIDTH=32, DEPTH=4: NAND(0xFFFF0000,0xFF00FF00)=0x00FFFFFF, NOR(0,0)=0xFFFFFFFF, and XNOR(a,a)=0xFFFFFFFF.
